dmem_responder: RTL

//  Data-memory responder for the multicycle RV32 core: the target side of the dmem_rd/dmem_we

---
 rtl/dmem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-organised data RAM responder with byte-lane writes, wait states, one-cycle ack and range error.
// Optional MMIO output word at 32'hFFFF_FFF0 enabled by DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_rd,
  input  logic [3:0]  dmem_we,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ack,
  output logic        dmem_err
`ifdef DMEM_RESPONDER_MMIO_EN
  ,
  output logic [31:0] mmio_data,
  output logic        mmio_valid
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         we_q;
  logic [31:0]        mem [DEPTH_WORDS];

  logic               req_c;
  logic [31:0]        op_addr_c, op_wdata_c, offset_c;
  logic [3:0]         op_we_c;
  logic               op_wr_c, oor_c, commit_c, is_mmio_c;
  logic [IDX_W-1:0]   idx_c;

  assign req_c = dmem_rd | (|dmem_we);

  // In IDLE the commit may happen on the sampling edge itself, so use live inputs there.
  assign op_addr_c  = (state_q == S_IDLE) ? dmem_addr  : addr_q;
  assign op_wdata_c = (state_q == S_IDLE) ? dmem_wdata : wdata_q;
  assign op_we_c    = (state_q == S_IDLE) ? dmem_we    : we_q;
  assign op_wr_c    = |op_we_c;

  assign offset_c = op_addr_c - BASE_ADDR;
  assign oor_c    = (op_addr_c < BASE_ADDR) || ((offset_c >> 2) >= 32'(DEPTH_WORDS));
  assign idx_c    = offset_c[IDX_W+1:2];
  assign commit_c = (state_d == S_RESP);

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
  assign is_mmio_c = (op_addr_c == MMIO_ADDR);
`else
  assign is_mmio_c = 1'b0;
`endif

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and registered response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      dmem_rdata <= '0;
      dmem_ack   <= 1'b0;
      dmem_err   <= 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
      mmio_data  <= '0;
      mmio_valid <= 1'b0;
`endif
    end else begin
      if (state_q == S_IDLE && req_c) begin
        addr_q  <= dmem_addr;
        wdata_q <= dmem_wdata;
        we_q    <= dmem_we;
      end
      dmem_ack <= commit_c;
      dmem_err <= commit_c && oor_c && !is_mmio_c;
      if (commit_c && !op_wr_c) begin
        if (is_mmio_c) begin
`ifdef DMEM_RESPONDER_MMIO_EN
          dmem_rdata <= mmio_data;
`endif
        end else if (oor_c) begin
          dmem_rdata <= '0;
        end else begin
          dmem_rdata <= mem[idx_c];
        end
      end
`ifdef DMEM_RESPONDER_MMIO_EN
      mmio_valid <= commit_c && op_wr_c && is_mmio_c;
      if (commit_c && op_wr_c && is_mmio_c) begin
        for (int i = 0; i < 4; i++) begin
          if (op_we_c[i]) mmio_data[8*i +: 8] <= op_wdata_c[8*i +: 8];
        end
      end
`endif
    end
  end

  // RAM array keeps contents across reset; rstn gating drops writes while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && commit_c && op_wr_c && !oor_c && !is_mmio_c) begin
      for (int i = 0; i < 4; i++) begin
        if (op_we_c[i]) mem[idx_c][8*i +: 8] <= op_wdata_c[8*i +: 8];
      end
    end
  end

endmodule
